call_scheduler: RTL and testbench
=================================

# call_scheduler

Collective-control request scheduler for the 5-floor elevator. It latches debounced hall (`btn_outer`) and car (`btn_inner`) call pulses into a pending-call register. It runs an IDLE/UP/DOWN direction FSM and produces the registered destination floor consumed by `car_indicator` as `dest`. It sits between the pushbutton debouncers and `car_indicator`, and clears a call when the car reports arrival at that floor.

## Interface
- `NUM_FLOORS`, 5, number of floors; fixed at 5 for this design.
- `FLOOR_W`, 3, floor-index width; floors are encoded 0..4.

- `clk`  in  1  system clock; all state is updated on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `btn_outer`  in  5  hall-call pulses, one cycle wide; bit i = floor i.
- `btn_inner`  in  5  car-call pulses, one cycle wide; bit i = floor i.
- `car_location`  in  3  current floor from `car_indicator`; values 5..7 are invalid.
- `arrived`  in  1  one-cycle pulse from `car_indicator` when the car stops and the doors open at `car_location`.
- `dest`  out  3  target floor for `car_indicator`.
- `dest_valid`  out  1  `dest` holds a real pending call.
- `dir_up`  out  1  FSM is in UP.
- `dir_down`  out  1  FSM is in DOWN.
- `call_lamp`  out  5  pending-call register, driven directly to the indicator lamps.

## Operation
- Pending register: `pending <= (pending | btn_outer | btn_inner) & ~clr`.
  - `clr` is the one-hot decode of `car_location` when `arrived` is high and `car_location` is valid; otherwise `clr` is 0.
  - If a press and a clear hit the same floor in the same cycle, the clear wins.
- Search terms, computed from registered `pending` and current `car_location`:
  - `above`: nearest pending floor ≥ `car_location`.
  - `below`: nearest pending floor ≤ `car_location`.
- FSM states: IDLE, UP, DOWN.
  - IDLE, no pending calls: stay in IDLE. `dest_valid` = 0 and `dest` = `car_location`.
  - IDLE, pending calls exist: go to UP or DOWN, whichever direction holds the nearer pending floor. A distance tie selects UP. A call only at the current floor also selects UP, which then serves it as `above`.
  - UP: `dest` = `above`. If no floor ≥ `car_location` is pending, go to DOWN if any floor below is pending, else go to IDLE.
  - DOWN: mirror image of UP, using `below`.
- `dest`, `dest_valid` and the direction outputs are registered together.
  - `dest_valid` = 1 exactly when the next state is UP or DOWN.
- Invalid `car_location` (5..7):
  - FSM, `dest`, `dest_valid` and direction outputs hold their values.
  - New presses still latch into `pending`.
  - `arrived` is ignored.

## Timing
- Reset values: `pending` = 0, state = IDLE, `dest` = 0, `dest_valid` = 0, `dir_up` = 0, `dir_down` = 0, `call_lamp` = 0.
- Reset is asynchronous. Asserting `resetn` low mid-travel discards all pending calls.
- Press-to-lamp latency: a pulse in cycle N appears on `call_lamp` in cycle N+1.
- Press-to-destination latency: the same pulse is reflected on `dest`/`dest_valid` in cycle N+2.
- Arrival clear: `arrived` in cycle N clears the lamp in N+1. The next `dest` appears in N+2.
- A change of `car_location` alone updates `dest` one cycle later.
- Held or repeated pulses on an already-pending floor have no effect, except as described under Configuration.

## Configuration
- Macro: `CALL_CANCEL_EN`.
- With the macro defined: a `btn_inner` pulse on a floor whose bit is already set in `pending` clears that bit. The clear applies only if no `btn_outer` pulse for the same floor arrives in the same cycle.
- Without the macro: `btn_inner` pulses only ever set bits.
- `btn_outer` pulses never cancel a call, with or without the macro.

## Structure
- Shared package `elevator_pkg` holds:
  - `NUM_FLOORS` and `FLOOR_W`;
  - the state enum `dir_state_t` {IDLE, UP, DOWN};
  - the constant `FLOOR_INVALID_MIN` = 5.
  - `car_indicator` also imports this package.
- One combinational sub-module, `call_search`: takes `pending` and `car_location` and returns `above`, `below`, `any_above`, `any_below` and `any_here`.

## Test plan
- After reset, pulse `btn_inner[3]` with `car_location` = 0. Required: `call_lamp` = 01000 in cycle N+1. In cycle N+2, `dest` = 3, `dest_valid` = 1, `dir_up` = 1.
- With the car at floor 2 in IDLE, pulse floors 0 and 4 together. Required: equal distance, so UP with `dest` = 4. After `arrived` at floor 4: state DOWN, `dest` = 0. After `arrived` at floor 0: IDLE, `dest_valid` = 0.
- In UP heading to floor 4, with `car_location` stepping 1 → 2, pulse `btn_outer[3]`. Required: `dest` switches to 3 and floor 4 stays pending.
- Pulse `btn_outer[2]` in the same cycle as `arrived` with `car_location` = 2. Required: bit 2 is clear afterwards.
- Drive `car_location` = 6 and pulse `btn_inner[1]`. Required: `dest`, `dest_valid` and direction outputs are frozen, while `call_lamp[1]` sets.
- With `CALL_CANCEL_EN` defined, pulse `btn_inner[3]` twice, 5 cycles apart. Required: `call_lamp[3]` reads 1 then 0, and the FSM returns to IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor width and direction states.
// Imported by call_scheduler, call_search and car_indicator.
package elevator_pkg;

    localparam int NUM_FLOORS = 5;
    localparam int FLOOR_W    = 3;

    localparam logic [FLOOR_W-1:0] FLOOR_INVALID_MIN = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_state_t;

endpackage

// File: rtl/call_search.sv
// Nearest pending floor at/above and at/below the car, plus strict
// above/below/here presence flags.
module call_search
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_location,
    output logic [FLOOR_W-1:0]    above,
    output logic [FLOOR_W-1:0]    below,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  any_here
);

    always_comb begin
        above     = '0;
        below     = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        any_here  = 1'b0;
        // Descending scan: the lowest qualifying floor is written last.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i >= int'(car_location)))
                above = FLOOR_W'(i);
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i <= int'(car_location)))
                below = FLOOR_W'(i);
            if (pending[i] && (i > int'(car_location)))
                any_above = 1'b1;
            if (pending[i] && (i < int'(car_location)))
                any_below = 1'b1;
            if (pending[i] && (i == int'(car_location)))
                any_here = 1'b1;
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Collective-control call scheduler: pending-call register and IDLE/UP/DOWN
// direction FSM. Optional macro CALL_CANCEL_EN lets a repeat car call cancel.
module call_scheduler
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_FLOORS-1:0] btn_outer,
    input  logic [NUM_FLOORS-1:0] btn_inner,
    input  logic [FLOOR_W-1:0]    car_location,
    input  logic                  arrived,
    output logic [FLOOR_W-1:0]    dest,
    output logic                  dest_valid,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic [NUM_FLOORS-1:0] call_lamp
);

    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] pending_nxt;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] cancel;
    logic                  loc_ok;

    logic [FLOOR_W-1:0] above;
    logic [FLOOR_W-1:0] below;
    logic               any_above;
    logic               any_below;
    logic               any_here;
    logic               has_ge;
    logic               has_le;
    logic [FLOOR_W-1:0] dist_up;
    logic [FLOOR_W-1:0] dist_dn;

    dir_state_t         state;
    dir_state_t         state_nxt;
    logic [FLOOR_W-1:0] dest_nxt;

    assign loc_ok = (car_location < FLOOR_INVALID_MIN);

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            clr[i] = arrived && loc_ok &&
                     (car_location == FLOOR_W'(i));
    end

`ifdef CALL_CANCEL_EN
    // A hall press on the same floor keeps the call alive.
    assign cancel = btn_inner & pending & ~btn_outer;
`else
    assign cancel = '0;
`endif

    assign pending_nxt = (pending | btn_outer | btn_inner)
                       & ~cancel & ~clr;

    call_search u_search (
        .pending      (pending),
        .car_location (car_location),
        .above        (above),
        .below        (below),
        .any_above    (any_above),
        .any_below    (any_below),
        .any_here     (any_here)
    );

    assign has_ge  = any_above | any_here;
    assign has_le  = any_below | any_here;
    assign dist_up = above - car_location;
    assign dist_dn = car_location - below;

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE: begin
                // Ties, including a call at the current floor, go UP.
                if (has_ge && (!has_le || dist_up <= dist_dn))
                    state_nxt = UP;
                else if (has_le)
                    state_nxt = DOWN;
            end
            UP: begin
                if (has_ge)
                    state_nxt = UP;
                else if (any_below)
                    state_nxt = DOWN;
            end
            DOWN: begin
                if (has_le)
                    state_nxt = DOWN;
                else if (any_above)
                    state_nxt = UP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dest_nxt = car_location;
        if (state_nxt == UP)
            dest_nxt = above;
        else if (state_nxt == DOWN)
            dest_nxt = below;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending    <= '0;
            state      <= IDLE;
            dest       <= '0;
            dest_valid <= 1'b0;
        end else begin
            pending <= pending_nxt;
            // An invalid floor reading freezes the direction logic.
            if (loc_ok) begin
                state      <= state_nxt;
                dest       <= dest_nxt;
                dest_valid <= (state_nxt != IDLE);
            end
        end
    end

    assign dir_up    = (state == UP);
    assign dir_down  = (state == DOWN);
    assign call_lamp = pending;

endmodule

// File: tb/tb_call_scheduler.sv
// Testbench for call_scheduler: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural model.
module tb_call_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] btn_outer = '0;
    logic [4:0] btn_inner = '0;
    logic [2:0] car_location = '0;
    logic       arrived = 1'b0;
    logic [2:0] dest;
    logic       dest_valid;
    logic       dir_up;
    logic       dir_down;
    logic [4:0] call_lamp;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: direction 0 idle, 1 up, 2 down.
    bit [4:0] m_pend;
    int       m_dir;
    int       m_dest;
    bit       m_valid;

    call_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .btn_outer    (btn_outer),
        .btn_inner    (btn_inner),
        .car_location (car_location),
        .arrived      (arrived),
        .dest         (dest),
        .dest_valid   (dest_valid),
        .dir_up       (dir_up),
        .dir_down     (dir_down),
        .call_lamp    (call_lamp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_dir   = 0;
        m_dest  = 0;
        m_valid = 0;
    endtask

    // Applies one rising edge to the model using the inputs held now.
    task automatic model_edge();
        int lv;
        int du;
        int dd;
        bit [4:0] nxt;
        if (!resetn) begin
            model_reset();
            return;
        end
        lv = int'(car_location);
        if (lv < 5) begin
            du = -1;
            dd = -1;
            for (int d = 0; d < 5; d++) begin
                if (du < 0 && lv + d < 5 && m_pend[lv + d]) du = d;
                if (dd < 0 && lv - d >= 0 && m_pend[lv - d]) dd = d;
            end
            case (m_dir)
                0: m_dir = (du >= 0 && (dd < 0 || du <= dd)) ? 1 :
                           (dd >= 0) ? 2 : 0;
                1: m_dir = (du >= 0) ? 1 : (dd >= 0) ? 2 : 0;
                default: m_dir = (dd >= 0) ? 2 : (du >= 0) ? 1 : 0;
            endcase
            m_valid = (m_dir != 0);
            m_dest  = (m_dir == 1) ? lv + du :
                      (m_dir == 2) ? lv - dd : lv;
        end
        nxt = m_pend | btn_outer | btn_inner;
`ifdef CALL_CANCEL_EN
        for (int i = 0; i < 5; i++)
            if (btn_inner[i] && m_pend[i] && !btn_outer[i]) nxt[i] = 1'b0;
`endif
        if (arrived && lv < 5) nxt[lv] = 1'b0;
        m_pend = nxt;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".lamp"},  int'(call_lamp),  int'(m_pend));
        check({tag, ".valid"}, int'(dest_valid), int'(m_valid));
        check({tag, ".up"},    int'(dir_up),     int'(m_dir == 1));
        check({tag, ".down"},  int'(dir_down),   int'(m_dir == 2));
        check({tag, ".dest"},  int'(dest),       m_dest);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        btn_outer = '0;
        btn_inner = '0;
        arrived   = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step("rst");
        step("rst");
        resetn = 1'b1;
    endtask

    logic [2:0] hold_dest;
    logic       hold_valid;
    logic       hold_up;
    logic       hold_down;

    initial begin
        model_reset();
        #1;
        check("reset.lamp",  int'(call_lamp),  0);
        check("reset.valid", int'(dest_valid), 0);
        check("reset.dest",  int'(dest),       0);
        check("reset.dir",   int'({dir_up, dir_down}), 0);
        do_reset();

        // Car call to floor 3 from floor 0.
        car_location = 3'd0;
        btn_inner    = 5'b01000;
        step("p1a");
        check("p1.lamp", int'(call_lamp), 5'b01000);
        step("p1b");
        check("p1.dest",  int'(dest), 3);
        check("p1.valid", int'(dest_valid), 1);
        check("p1.up",    int'(dir_up), 1);

        // Tie at floor 2 between floors 0 and 4 goes up first.
        do_reset();
        car_location = 3'd2;
        step("p2idle");
        btn_outer = 5'b10001;
        step("p2a");
        step("p2b");
        check("p2.tie_up",   int'(dir_up), 1);
        check("p2.tie_dest", int'(dest), 4);
        car_location = 3'd4;
        arrived      = 1'b1;
        step("p2c");
        step("p2d");
        check("p2.down",      int'(dir_down), 1);
        check("p2.down_dest", int'(dest), 0);
        car_location = 3'd0;
        arrived      = 1'b1;
        step("p2e");
        step("p2f");
        check("p2.idle_valid", int'(dest_valid), 0);
        check("p2.idle_dir",   int'({dir_up, dir_down}), 0);

        // Intermediate hall call while heading up.
        do_reset();
        car_location = 3'd1;
        btn_inner    = 5'b10000;
        step("p3a");
        step("p3b");
        car_location = 3'd2;
        step("p3c");
        btn_outer = 5'b01000;
        step("p3d");
        step("p3e");
        check("p3.dest",    int'(dest), 3);
        check("p3.keep4",   int'(call_lamp[4]), 1);

        // Invalid location freezes direction logic but latches presses.
        hold_dest  = dest;
        hold_valid = dest_valid;
        hold_up    = dir_up;
        hold_down  = dir_down;
        car_location = 3'd6;
        btn_inner    = 5'b00010;
        arrived      = 1'b1;
        step("p5a");
        check("p5.lamp1", int'(call_lamp[1]), 1);
        step("p5b");
        check("p5.dest",  int'(dest), int'(hold_dest));
        check("p5.valid", int'(dest_valid), int'(hold_valid));
        check("p5.dir",   int'({dir_up, dir_down}),
              int'({hold_up, hold_down}));

        // Press and arrival clear on the same floor: clear wins.
        do_reset();
        car_location = 3'd2;
        btn_outer    = 5'b00100;
        arrived      = 1'b1;
        step("p4a");
        check("p4.clr", int'(call_lamp[2]), 0);
        step("p4b");
        check("p4.idle", int'(dest_valid), 0);

`ifdef CALL_CANCEL_EN
        do_reset();
        car_location = 3'd0;
        btn_inner    = 5'b01000;
        step("p6a");
        check("p6.set", int'(call_lamp[3]), 1);
        repeat (4) step("p6w");
        btn_inner = 5'b01000;
        step("p6b");
        check("p6.cancel", int'(call_lamp[3]), 0);
        step("p6c");
        check("p6.idle", int'({dest_valid, dir_up, dir_down}), 0);
`endif

        // Random traffic, with one asynchronous reset mid-run.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                car_location = 3'($urandom_range(5, 7));
            else
                car_location = 3'($urandom_range(0, 4));
            btn_outer = 5'($urandom & $urandom & $urandom);
            btn_inner = 5'($urandom & $urandom & $urandom);
            arrived   = ($urandom_range(0, 3) == 0);
            if (i == 1500) begin
                #2;
                resetn = 1'b0;
                #1;
                model_reset();
                check("async.lamp",  int'(call_lamp), 0);
                check("async.valid", int'(dest_valid), 0);
                check("async.dest",  int'(dest), 0);
                check("async.dir",   int'({dir_up, dir_down}), 0);
                step("rnd_rst");
                resetn = 1'b1;
            end else begin
                step("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
